data_mem: RTL and testbench



---
 rtl/data_mem_pkg.sv | 15 +
 rtl/data_mem_array.sv | 32 +++
 rtl/data_mem.sv | 69 ++++++
 tb/tb_data_mem.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and types for the data_mem load/store target.
// Optional build macro: DATA_MEM_WRITE_THROUGH_EN (see data_mem.sv).
package data_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 2 ** DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] word_t;

    localparam logic R_W_WRITE = 1'b1;
    localparam logic R_W_READ  = 1'b0;

endpackage

// File: rtl/data_mem_array.sv
// Flop-based word storage with asynchronous clear, one write port and a
// combinational read port.
module data_mem_array
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DEPTH-1:0][DATA_W-1:0] mem_r;

    // Storage update: whole array clears on reset, one word written per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
        end else if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/data_mem.sv
// 256 x 8 single-port synchronous data memory with registered read data.
// Build macro DATA_MEM_WRITE_THROUGH_EN: write data also appears on data_out.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address_bus,
    input  logic [DATA_W-1:0] data_in,
    input  logic              r_w,
    output logic [DATA_W-1:0] data_out
);

    logic              we_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [DATA_W-1:0] out_nxt_s;

    // Decode the bus direction.
    always_comb begin
        we_s = 1'b0;
        if (r_w == R_W_WRITE) begin
            we_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s),
        .waddr (address_bus),
        .wdata (data_in),
        .raddr (address_bus),
        .rdata (rd_data_s)
    );

    // Select next data_out: array word on reads, hold or pass-through on writes.
    always_comb begin
        out_nxt_s = data_out;
        if (we_s) begin
`ifdef DATA_MEM_WRITE_THROUGH_EN
            out_nxt_s = data_in;
`else
            out_nxt_s = data_out;
`endif
        end else begin
            out_nxt_s = rd_data_s;
        end
    end

    // Read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else begin
            data_out <= out_nxt_s;
        end
    end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus queues expected data_out per edge,
// a monitor pops and compares just after each rising edge.
module tb_data_mem;
    import data_mem_pkg::*;

    typedef struct {
        word_t exp;
        string name;
    } sb_entry_t;

    logic  clk;
    logic  rst_n;
    addr_t address_bus;
    word_t data_in;
    logic  r_w;
    word_t data_out;

    sb_entry_t sb_q[$];
    word_t     cur_out;
    int        n_checks;
    int        n_errors;

    data_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .address_bus (address_bus),
        .data_in     (data_in),
        .r_w         (r_w),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        n_checks = n_checks + 1;
        if (act != req) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Drive one cycle's inputs now (before the coming rising edge) and queue expectation.
    task automatic op_now(input logic rw, input addr_t a, input word_t d, input word_t rd_exp,
                          input string name);
        sb_entry_t e;
        address_bus = a;
        data_in     = d;
        r_w         = rw;
        if (rw == R_W_WRITE) begin
`ifdef DATA_MEM_WRITE_THROUGH_EN
            e.exp = d;
`else
            e.exp = cur_out;
`endif
        end else begin
            e.exp = rd_exp;
        end
        e.name  = name;
        cur_out = e.exp;
        sb_q.push_back(e);
    endtask

    task automatic wr(input addr_t a, input word_t d, input string name);
        @(negedge clk);
        op_now(R_W_WRITE, a, d, 8'h00, name);
    endtask

    task automatic rd(input addr_t a, input word_t exp, input string name);
        @(negedge clk);
        op_now(R_W_READ, a, 8'h00, exp, name);
    endtask

    // Monitor: compare data_out just after every edge that has a queued expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                sb_entry_t e;
                e = sb_q.pop_front();
                check(e.name, int'(data_out), int'(e.exp));
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cur_out     = 8'h00;
        rst_n       = 1'b0;
        address_bus = 8'h00;
        data_in     = 8'h00;
        r_w         = R_W_READ;
        #1;
        check("reset_out", int'(data_out), 0);
        repeat (2) @(posedge clk);

        // Release at a negedge; the first read follows on the next edge.
        @(negedge clk);
        rst_n = 1'b1;
        op_now(R_W_READ, 8'd0, 8'h00, 8'h00, "rst_rd0");
        rd(8'd1,   8'h00, "rst_rd1");
        rd(8'd255, 8'h00, "rst_rd255");

        // Basic write then read.
        wr(8'd0, 8'd1, "wr0_1");
        wr(8'd1, 8'd7, "wr1_7");
        rd(8'd0, 8'd1, "rd0_1");
        rd(8'd1, 8'd7, "rd1_7");

        // Boundary addresses and their neighbours.
        wr(8'd0,   8'hAA, "wr0_aa");
        wr(8'd255, 8'h55, "wr255_55");
        rd(8'd0,   8'hAA, "rd0_aa");
        rd(8'd255, 8'h55, "rd255_55");
        rd(8'd1,   8'h07, "rd1_keep");
        rd(8'd254, 8'h00, "rd254_0");

        // Write then read same address; data_out during the write is checked too.
        rd(8'd255, 8'h55, "rd255_pre");
        wr(8'd16,  8'h3C, "wr16_hold");
        rd(8'd16,  8'h3C, "rd16_3c");

        // Reset mid-operation.
        wr(8'd5, 8'hFF, "wr5_ff");
        rd(8'd5, 8'hFF, "rd5_ff");
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("async_rst_out", int'(data_out), 0);
        #1;
        rst_n   = 1'b1;
        cur_out = 8'h00;
        op_now(R_W_READ, 8'd5, 8'h00, 8'h00, "rd5_after_rst");
        rd(8'd0,   8'h00, "rd0_after_rst");
        rd(8'd255, 8'h00, "rd255_after_rst");

        // Overwrite, held write, held read, successive reads.
        wr(8'd2, 8'h11, "wr2_11");
        wr(8'd2, 8'h22, "wr2_22");
        wr(8'd2, 8'h22, "wr2_22_held");
        rd(8'd2, 8'h22, "rd2_22");
        rd(8'd2, 8'h22, "rd2_held");
        wr(8'd0, 8'h09, "wr0_09");
        wr(8'd1, 8'h08, "wr1_08");
        rd(8'd0, 8'h09, "seq_rd0");
        rd(8'd1, 8'h08, "seq_rd1");
        rd(8'd2, 8'h22, "seq_rd2");
        rd(8'd3, 8'h00, "seq_rd3");

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
